// File: rtl/counter_pkg.sv
// Shared counter definitions: count direction encoding and the load clamp helper
// used by loadable counters.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Values above the modulus ceiling are pinned to it rather than wrapped.
  function automatic logic [31:0] clamp_load(input logic [31:0] d, input logic [31:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Modulo-(MAX+1) up/down counter with enable, sync load and registered wrap pulse; one-edge latency.
// Define UPDOWN_MOD_COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int N   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         wrap
);

  if (MAX < 1 || MAX > (2 ** N) - 1) begin : g_bad_max
    $error("updown_mod_counter: MAX=%0d outside 1..2^N-1 for N=%0d", MAX, N);
  end

  localparam logic [N-1:0] MAX_V = N'(MAX);
  localparam logic [N-1:0] ONE   = N'(1);

  logic [N-1:0] q_nxt;
  logic         wrap_nxt;
  dir_e         dir;

  assign dir = dir_e'(up);

  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = N'(clamp_load(32'(D), 32'(MAX)));
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (Q == MAX_V) begin
          wrap_nxt = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
          q_nxt    = MAX_V;
`else
          q_nxt    = '0;
`endif
        end else begin
          q_nxt = Q + ONE;
        end
      end else begin
        if (Q == '0) begin
          wrap_nxt = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
          q_nxt    = '0;
`else
          q_nxt    = MAX_V;
`endif
        end else begin
          q_nxt = Q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
